// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the word arbiter and the DataMemory.
// slave  : seen from the arbiter (requests in, acks/strobes out).
// master : seen from everything around the arbiter (requesters and memory).
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // requester port 0 (CPU load/store)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;
  // requester port 1 (debug/DMA loader)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;
  // status
  logic              busy;
  // memory side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read_data,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output busy,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read_data,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  busy,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 256-byte big-endian word memory
// with synchronous write and registered read. One access in flight at a time:
// IDLE (grant) -> ISSUE (strobe) -> CAPT (capture) -> IDLE with a 1-cycle ack.
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to reject granted requests
// whose address is not word aligned (errN pulse instead of a memory access).
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic               clock,
  input logic               reset_n,
  data_mem_arbiter_if.slave bus
);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  // per-port views of the requester inputs, indexed by port number
  logic [1:0]        req_in;
  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];

  assign req_in      = {bus.req1, bus.req0};
  assign we_in       = {bus.we1, bus.we0};
  assign addr_in[0]  = bus.addr0;
  assign addr_in[1]  = bus.addr1;
  assign wdata_in[0] = bus.wdata0;
  assign wdata_in[1] = bus.wdata1;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              owner_reg, owner_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              reject_reg, reject_next;

  logic              grant;
  logic [1:0]        eligible;
  logic [1:0]        done_ack;
  logic [1:0]        done_err;
  logic              capture;
  logic              mem_write_c;
  logic              mem_read_c;

  logic              ack_reg   [2];
  logic              err_reg   [2];
  logic [DATA_W-1:0] rdata_reg [2];

  // A port still showing its ack is dropping req this cycle, so it cannot
  // be granted again until the pulse is over.
  assign eligible = req_in & ~{ack_reg[1], ack_reg[0]};

  // State and transaction latches.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      reject_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      reject_reg     <= reject_next;
    end
  end

  // Arbitration, sequencing and memory strobes.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    reject_next     = reject_reg;
    grant           = 1'b0;
    done_ack        = 2'b00;
    done_err        = 2'b00;
    capture         = 1'b0;
    mem_write_c     = 1'b0;
    mem_read_c      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (eligible != 2'b00) begin
          // on a tie the port that did not win last time goes first
          grant           = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];
          owner_next      = grant;
          we_next         = we_in[grant];
          addr_next       = addr_in[grant];
          wdata_next      = wdata_in[grant];
          last_grant_next = grant;
          reject_next     = ALIGN_CHECK && (addr_in[grant][1:0] != 2'b00);
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        // a rejected request walks the same path with strobes held low,
        // so err has exactly the same timing as ack
        mem_write_c = !reject_reg && we_reg;
        mem_read_c  = !reject_reg && !we_reg;
        state_next  = CAPT;
      end
      CAPT: begin
        if (reject_reg) begin
          done_err[owner_reg] = 1'b1;
        end else begin
          done_ack[owner_reg] = 1'b1;
          capture             = !we_reg;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Completion/reject pulses and the read data held for each port.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          ack_reg[gi]   <= 1'b0;
          err_reg[gi]   <= 1'b0;
          rdata_reg[gi] <= '0;
        end else begin
          ack_reg[gi] <= done_ack[gi];
          err_reg[gi] <= done_err[gi];
          if (done_ack[gi] && capture) begin
            rdata_reg[gi] <= bus.mem_read_data;
          end
        end
      end
    end
  endgenerate

  assign bus.ack0           = ack_reg[0];
  assign bus.ack1           = ack_reg[1];
  assign bus.err0           = err_reg[0];
  assign bus.err1           = err_reg[1];
  assign bus.rdata0         = rdata_reg[0];
  assign bus.rdata1         = rdata_reg[1];
  assign bus.busy           = (state_reg != IDLE);
  assign bus.mem_address    = addr_reg;
  assign bus.mem_write_data = wdata_reg;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_read       = mem_read_c;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: DataMemory model on the memory side, a byte-array
// reference of memory contents, directed steps followed by random accesses.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic preload = 1'b1;

  always #5 clock = ~clock;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- DataMemory model ----------------
  logic [7:0] dmem [256];

  function automatic logic [7:0] init_byte(input int i);
    if (i >= 4 && i < 8) return 8'h11;
    return 8'(i * 7 + 3);
  endfunction

  always @(posedge clock) begin
    logic [7:0] a0, a1, a2, a3;
    a0 = bus.mem_address;
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    if (preload) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_byte(i);
    end else if (bus.mem_write) begin
      dmem[a0] <= bus.mem_write_data[31:24];
      dmem[a1] <= bus.mem_write_data[23:16];
      dmem[a2] <= bus.mem_write_data[15:8];
      dmem[a3] <= bus.mem_write_data[7:0];
    end
    if (bus.mem_read) bus.mem_read_data <= {dmem[a0], dmem[a1], dmem[a2], dmem[a3]};
  end

  // strobe monitor
  int rd_pulses = 0;
  int wr_pulses = 0;
  int both_cnt  = 0;
  always @(posedge clock) begin
    if (bus.mem_read)  rd_pulses <= rd_pulses + 1;
    if (bus.mem_write) wr_pulses <= wr_pulses + 1;
    if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] last_rd [2];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd3)]};
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [31:0] d);
    ref_mem[a]              = d[31:24];
    ref_mem[8'(a + 8'd1)]   = d[23:16];
    ref_mem[8'(a + 8'd2)]   = d[15:8];
    ref_mem[8'(a + 8'd3)]   = d[7:0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [7:0] a,
                       input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction

  function automatic logic get_err(input int p);
    return (p == 0) ? bus.err0 : bus.err1;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  // One isolated access from an idle arbiter, checked against the model.
  task automatic run_access(input string tag, input int p, input logic w,
                            input logic [7:0] a, input logic [31:0] d);
    int          lat;
    bit          done;
    int          rd0, wr0;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        got_ack, got_err;
    logic [31:0] got_rd;
    rd0     = rd_pulses;
    wr0     = wr_pulses;
    exp_err = ALIGN_ON && (a[1:0] != 2'b00);
    if (exp_err) begin
      exp_rd = last_rd[p];
    end else if (w) begin
      exp_rd = last_rd[p];
      ref_write(a, d);
    end else begin
      exp_rd = ref_word(a);
    end
    drive(p, 1'b1, w, a, d);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      // owner's inputs change after the grant; the latched request must win
      if (lat == 1) drive(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
      if (get_ack(p) || get_err(p)) done = 1'b1;
    end
    got_ack = get_ack(p);
    got_err = get_err(p);
    got_rd  = get_rdata(p);
    drive(p, 1'b0, 1'b0, 8'h00, 32'h0);
    check({tag, " latency"}, lat, 3);
    check({tag, " ack"}, 32'(got_ack), 32'(!exp_err));
    check({tag, " err"}, 32'(got_err), 32'(exp_err));
    check({tag, " rdata"}, got_rd, exp_rd);
    @(posedge clock); #1;
    check({tag, " pulse width"}, {get_ack(p), get_err(p)}, 0);
    check({tag, " read strobes"}, rd_pulses - rd0, 32'(!exp_err && !w));
    check({tag, " write strobes"}, wr_pulses - wr0, 32'(!exp_err && w));
    last_rd[p] = exp_rd;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   order [$];
    int   cyc;
    logic prev0, prev1;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h08, 32'h0);

    // reset held 3 cycles with both requests high
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("reset flags", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy,
                            bus.mem_write, bus.mem_read}, 0);
    end
    check("reset rdata0", bus.rdata0, 0);
    check("reset rdata1", bus.rdata1, 0);
    check("reset mem_address", bus.mem_address, 0);
    check("reset mem_write_data", bus.mem_write_data, 0);
    preload = 1'b0;
    reset_n = 1'b1;

    // both requests held continuously: expect 0,1,0,1
    cyc   = 0;
    prev0 = 1'b0;
    prev1 = 1'b0;
    while (order.size() < 4 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      check("contention single ack", 32'(bus.ack0 && bus.ack1), 0);
      check("contention ack width", 32'((bus.ack0 && prev0) || (bus.ack1 && prev1)), 0);
      prev0 = bus.ack0;
      prev1 = bus.ack1;
      if (bus.ack0) begin
        order.push_back(0);
        check("contention rdata0", bus.rdata0, ref_word(8'h04));
      end else if (bus.ack1) begin
        order.push_back(1);
        check("contention rdata1", bus.rdata1, ref_word(8'h08));
      end
      if (order.size() == 4) begin
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    check("contention ack count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check($sformatf("grant order %0d", i), order[i], i % 2);
    check("strobes never together", both_cnt, 0);
    last_rd[0] = ref_word(8'h04);
    last_rd[1] = ref_word(8'h08);
    @(posedge clock); #1;
    check("idle after contention", 32'(bus.busy), 0);

    // single read of the preloaded word
    run_access("read0 @04", 0, 1'b0, 8'h04, 32'h0);
    check("read0 preload value", bus.rdata0, 32'h11111111);

    // write then read back on port 1
    run_access("write1 @20", 1, 1'b1, 8'h20, 32'hDEADBEEF);
    run_access("read1 @20", 1, 1'b0, 8'h20, 32'h0);
    check("read1 value", bus.rdata1, 32'hDEADBEEF);
    check("mem bytes 20..23", {dmem[8'h20], dmem[8'h21], dmem[8'h22], dmem[8'h23]}, 32'hDEADBEEF);

    // reset during CAPT of a port 0 read
    drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midop busy before reset", 32'(bus.busy), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midop no ack0", 32'(bus.ack0), 0);
    check("midop busy cleared", 32'(bus.busy), 0);
    reset_n = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clock); #1;
    check("midop still no ack0", 32'(bus.ack0), 0);
    check("midop rdata0 cleared", bus.rdata0, 0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    run_access("read0 after reset", 0, 1'b0, 8'h04, 32'h0);

    // unaligned word and address wrap
    run_access("read0 @06", 0, 1'b0, 8'h06, 32'h0);
    run_access("write0 @FE", 0, 1'b1, 8'hFE, 32'hCAFEF00D);
    run_access("read1 @FE", 1, 1'b0, 8'hFE, 32'h0);

    // random accesses
    for (int k = 0; k < 40; k++) begin
      run_access($sformatf("rand%0d", k), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), $urandom);
    end
    check("strobes never together final", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
